// File: rtl/multi_player_clock_fsm_if.sv
// Bundle of the game-clock controls and display outputs for multi_player_clock_fsm.
// Latency: none, wires only.
// Backpressure: none; every signal is a plain level or a one-cycle pulse.
interface multi_player_clock_fsm_if #(
  parameter int N_PLAYERS = 2,
  parameter int CNT_W     = 10
) ();
  localparam int IW = (N_PLAYERS > 2) ? $clog2(N_PLAYERS) : 1;

  // Controls, driven by the button/tick front end.
  logic                       tick;
  logic [N_PLAYERS-1:0]       buttons;
  logic                       pause_btn;
  logic                       clear;

  // Status, consumed by the display and LED drivers.
  logic [N_PLAYERS*CNT_W-1:0] times;
  logic [IW-1:0]              active_idx;
  logic [IW-1:0]              loser_idx;
  logic                       flag;
  logic [1:0]                 o_state;
  logic                       low_time;

  modport master (
    output tick, buttons, pause_btn, clear,
    input  times, active_idx, loser_idx, flag, o_state, low_time
  );

  modport slave (
    input  tick, buttons, pause_btn, clear,
    output times, active_idx, loser_idx, flag, o_state, low_time
  );
endinterface

// File: rtl/multi_player_clock_fsm.sv
// N-player game clock: per-player countdown, handover with increment, pause, clear.
// Latency: every output is registered and reflects an input edge one cycle later.
// Backpressure: none; inputs are sampled every cycle. Optional macro CLOCK_WARN_EN enables low_time.
module multi_player_clock_fsm #(
  parameter int N_PLAYERS  = 2,
  parameter int CNT_W      = 10,
  parameter int START_TIME = 600,
  parameter int INCREMENT  = 0,
  parameter int WARN_TIME  = 30
) (
  input  logic                      clk,
  input  logic                      reset_n,
  multi_player_clock_fsm_if.slave   bus
);

  localparam int IW = (N_PLAYERS > 2) ? $clog2(N_PLAYERS) : 1;

  localparam logic [1:0] S_IDLE  = 2'b00;
  localparam logic [1:0] S_RUN   = 2'b01;
  localparam logic [1:0] S_PAUSE = 2'b10;
  localparam logic [1:0] S_WIN   = 2'b11;

  localparam logic [CNT_W-1:0] START_V  = CNT_W'(START_TIME);
  localparam logic [CNT_W-1:0] MAX_V    = '1;
  localparam logic [IW-1:0]    LAST_IDX = IW'(N_PLAYERS - 1);

  // Reject illegal configurations at elaboration time.
  generate
    if (N_PLAYERS < 2 || N_PLAYERS > 8) begin : g_bad_players
      $error("multi_player_clock_fsm: N_PLAYERS must be 2..8");
    end
    if (START_TIME < 0 || START_TIME >= (2 ** CNT_W) || INCREMENT < 0 || WARN_TIME < 0) begin : g_bad_times
      $error("multi_player_clock_fsm: START_TIME/INCREMENT/WARN_TIME out of range");
    end
  endgenerate

  // Registered state and outputs.
  logic [1:0]           r_state;
  logic [CNT_W-1:0]     r_times [N_PLAYERS];
  logic [IW-1:0]        r_active;
  logic [IW-1:0]        r_loser;
  logic                 r_flag;

  // Edge-detect history. r_armed stays low for the first cycle after reset
  // so a button already held during reset release is not seen as a press.
  logic [N_PLAYERS-1:0] r_btn_prev;
  logic                 r_pause_prev;
  logic                 r_armed;

  // Next-state values.
  logic [1:0]           w_nxt_state;
  logic [CNT_W-1:0]     w_nxt_times [N_PLAYERS];
  logic [IW-1:0]        w_nxt_active;
  logic [IW-1:0]        w_nxt_loser;
  logic                 w_nxt_flag;

  logic [N_PLAYERS-1:0] w_btn_rise;
  logic                 w_pause_rise;
  logic [IW-1:0]        w_first_idx;
  logic [31:0]          w_sum;
  logic [CNT_W-1:0]     w_inc_val;
  logic [CNT_W-1:0]     w_dec_val;
  logic [N_PLAYERS*CNT_W-1:0] w_times_flat;

  function automatic logic [IW-1:0] f_next_idx(input logic [IW-1:0] idx);
    return (idx == LAST_IDX) ? '0 : idx + IW'(1);
  endfunction

  assign w_btn_rise   = bus.buttons & ~r_btn_prev & {N_PLAYERS{r_armed}};
  assign w_pause_rise = bus.pause_btn & ~r_pause_prev & r_armed;

  // Saturating increment and plain decrement of the running player's counter.
  assign w_sum     = 32'(r_times[r_active]) + 32'(INCREMENT);
  assign w_inc_val = (w_sum > 32'(MAX_V)) ? MAX_V : w_sum[CNT_W-1:0];
  assign w_dec_val = r_times[r_active] - CNT_W'(1);

  // Lowest-numbered pressed button, used when several start the game at once.
  always_comb begin
    w_first_idx = '0;
    for (int k = N_PLAYERS - 1; k >= 0; k--) begin
      if (w_btn_rise[k]) w_first_idx = IW'(k);
    end
  end

  // Game state machine and counter updates; clear overrides everything.
  always_comb begin
    w_nxt_state  = r_state;
    w_nxt_times  = r_times;
    w_nxt_active = r_active;
    w_nxt_loser  = r_loser;
    w_nxt_flag   = r_flag;

    if (bus.clear) begin
      w_nxt_state  = S_IDLE;
      for (int k = 0; k < N_PLAYERS; k++) w_nxt_times[k] = START_V;
      w_nxt_active = '0;
      w_nxt_loser  = '0;
      w_nxt_flag   = 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          for (int k = 0; k < N_PLAYERS; k++) w_nxt_times[k] = START_V;
          if (|w_btn_rise) begin
            w_nxt_active = f_next_idx(w_first_idx);
            w_nxt_state  = S_RUN;
          end
        end
        S_RUN: begin
          // A handover suppresses a coincident tick.
          if (w_btn_rise[r_active]) begin
            w_nxt_times[r_active] = w_inc_val;
            w_nxt_active          = f_next_idx(r_active);
          end else if (bus.tick && (r_times[r_active] != '0)) begin
            w_nxt_times[r_active] = w_dec_val;
            if (w_dec_val == '0) begin
              w_nxt_state = S_WIN;
              w_nxt_loser = r_active;
              w_nxt_flag  = 1'b1;
            end
          end
          // Pause lands after any handover; a falling flag takes precedence.
          if (w_pause_rise && (w_nxt_state == S_RUN)) w_nxt_state = S_PAUSE;
        end
        S_PAUSE: begin
          if (w_pause_rise) w_nxt_state = S_RUN;
        end
        default: begin
          // WIN is terminal until clear or reset.
        end
      endcase
    end
  end

  // Main state and counter registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state  <= S_IDLE;
      for (int k = 0; k < N_PLAYERS; k++) r_times[k] <= START_V;
      r_active <= '0;
      r_loser  <= '0;
      r_flag   <= 1'b0;
    end else begin
      r_state  <= w_nxt_state;
      r_times  <= w_nxt_times;
      r_active <= w_nxt_active;
      r_loser  <= w_nxt_loser;
      r_flag   <= w_nxt_flag;
    end
  end

  // Input history for rising-edge detection.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_btn_prev   <= '0;
      r_pause_prev <= 1'b0;
      r_armed      <= 1'b0;
    end else begin
      r_btn_prev   <= bus.buttons;
      r_pause_prev <= bus.pause_btn;
      r_armed      <= 1'b1;
    end
  end

`ifdef CLOCK_WARN_EN
  logic r_low;
  logic w_nxt_low;

  // Warning derived from the same next values that load the counters.
  always_comb begin
    w_nxt_low = ((w_nxt_state == S_RUN) || (w_nxt_state == S_PAUSE)) &&
                (32'(w_nxt_times[w_nxt_active]) <= 32'(WARN_TIME)) &&
                (w_nxt_times[w_nxt_active] != '0);
  end

  // Registered low-time warning.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_low <= 1'b0;
    else          r_low <= w_nxt_low;
  end

  assign bus.low_time = r_low;
`else
  assign bus.low_time = 1'b0;
`endif

  // Flatten the counters for the display bus.
  always_comb begin
    w_times_flat = '0;
    for (int k = 0; k < N_PLAYERS; k++) w_times_flat[k*CNT_W +: CNT_W] = r_times[k];
  end

  assign bus.times      = w_times_flat;
  assign bus.active_idx = r_active;
  assign bus.loser_idx  = r_loser;
  assign bus.flag       = r_flag;
  assign bus.o_state    = r_state;

endmodule

// File: tb/tb_multi_player_clock_fsm.sv
// Bench for multi_player_clock_fsm: vector table, corner sequences, random vs model.
// Two instances: A (3 players, start 5) and B (4 players, start 1020, increment 2).
// Expectations for low_time follow CLOCK_WARN_EN as seen by this file.
module tb_multi_player_clock_fsm;
  localparam int A_N = 3, A_W = 10, A_START = 5,    A_INC = 0;
  localparam int B_N = 4, B_W = 10, B_START = 1020, B_INC = 2;
  localparam int WARN = 3;
`ifdef CLOCK_WARN_EN
  localparam bit WARN_ON = 1'b1;
`else
  localparam bit WARN_ON = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_a_n, rst_b_n;

  multi_player_clock_fsm_if #(.N_PLAYERS(A_N), .CNT_W(A_W)) bus_a ();
  multi_player_clock_fsm_if #(.N_PLAYERS(B_N), .CNT_W(B_W)) bus_b ();

  multi_player_clock_fsm #(.N_PLAYERS(A_N), .CNT_W(A_W), .START_TIME(A_START),
    .INCREMENT(A_INC), .WARN_TIME(WARN)) dut_a (.clk(clk), .reset_n(rst_a_n), .bus(bus_a));
  multi_player_clock_fsm #(.N_PLAYERS(B_N), .CNT_W(B_W), .START_TIME(B_START),
    .INCREMENT(B_INC), .WARN_TIME(WARN)) dut_b (.clk(clk), .reset_n(rst_b_n), .bus(bus_b));

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic       tick;
    logic [2:0] btn;
    logic       pse;
    logic       clr;
    int         st, act, los, flg, t0, t1, t2;
  } vec_t;
  vec_t tbl[31];

  function automatic vec_t mk(logic tk, logic [2:0] b, logic p, logic c,
                              int st, int act, int los, int flg, int t0, int t1, int t2);
    vec_t v;
    v.tick = tk; v.btn = b; v.pse = p; v.clr = c;
    v.st = st; v.act = act; v.los = los; v.flg = flg; v.t0 = t0; v.t1 = t1; v.t2 = t2;
    return v;
  endfunction

  function automatic bit exp_low(int st, int t);
    return WARN_ON && (st == 1 || st == 2) && (t <= WARN) && (t != 0);
  endfunction

  task automatic check_a(string name, int st, int act, int los, int flg, int t0, int t1, int t2);
    int gt[3];
    int et[3];
    bit ok;
    bit el;
    et[0] = t0; et[1] = t1; et[2] = t2;
    for (int k = 0; k < A_N; k++) gt[k] = int'(bus_a.times[k*A_W +: A_W]);
    el = exp_low(st, et[act]);
    ok = (int'(bus_a.o_state) == st) && (int'(bus_a.active_idx) == act) &&
         (int'(bus_a.flag) == flg) && (gt[0] == t0) && (gt[1] == t1) && (gt[2] == t2) &&
         (bus_a.low_time == el) && ((st != 3) || (int'(bus_a.loser_idx) == los));
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s: got st=%0d act=%0d los=%0d flag=%0d t=%0d/%0d/%0d low=%0d; want st=%0d act=%0d los=%0d flag=%0d t=%0d/%0d/%0d low=%0d",
               name, bus_a.o_state, bus_a.active_idx, bus_a.loser_idx, bus_a.flag,
               gt[0], gt[1], gt[2], bus_a.low_time, st, act, los, flg, t0, t1, t2, el);
    end
  endtask

  task automatic check_b(string name, int st, int act, int t0, int t1, int t2, int t3);
    int gt[4];
    bit ok;
    for (int k = 0; k < B_N; k++) gt[k] = int'(bus_b.times[k*B_W +: B_W]);
    ok = (int'(bus_b.o_state) == st) && (int'(bus_b.active_idx) == act) &&
         (bus_b.flag == 1'b0) && (bus_b.low_time == 1'b0) &&
         (gt[0] == t0) && (gt[1] == t1) && (gt[2] == t2) && (gt[3] == t3);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s: got st=%0d act=%0d flag=%0d low=%0d t=%0d/%0d/%0d/%0d; want st=%0d act=%0d flag=0 low=0 t=%0d/%0d/%0d/%0d",
               name, bus_b.o_state, bus_b.active_idx, bus_b.flag, bus_b.low_time,
               gt[0], gt[1], gt[2], gt[3], st, act, t0, t1, t2, t3);
    end
  endtask

  task automatic drive_a(logic tk, logic [2:0] b, logic p, logic c);
    bus_a.tick = tk; bus_a.buttons = b; bus_a.pause_btn = p; bus_a.clear = c;
    @(posedge clk); #1;
  endtask

  task automatic drive_b(logic tk, logic [3:0] b);
    bus_b.tick = tk; bus_b.buttons = b; bus_b.pause_btn = 1'b0; bus_b.clear = 1'b0;
    @(posedge clk); #1;
  endtask

  // Reference model of instance A, stepped once per clock from the spec's rules.
  int m_st, m_act, m_los, m_flg;
  int m_t[3];
  logic [2:0] m_pb;
  logic m_pp;

  task automatic model_a(logic tk, logic [2:0] b, logic p, logic c);
    logic [2:0] rise;
    bit prise;
    int sel;
    rise = b & ~m_pb;
    prise = p && !m_pp;
    m_pb = b; m_pp = p;
    if (c) begin
      m_st = 0; m_act = 0; m_flg = 0;
      for (int k = 0; k < A_N; k++) m_t[k] = A_START;
    end else if (m_st == 0) begin
      for (int k = 0; k < A_N; k++) m_t[k] = A_START;
      sel = -1;
      for (int k = 0; k < A_N; k++) if (rise[k] && sel < 0) sel = k;
      if (sel >= 0) begin m_act = (sel + 1) % A_N; m_st = 1; end
    end else if (m_st == 1) begin
      if (rise[m_act]) begin
        m_t[m_act] = (m_t[m_act] + A_INC > 1023) ? 1023 : m_t[m_act] + A_INC;
        m_act = (m_act + 1) % A_N;
      end else if (tk && m_t[m_act] > 0) begin
        m_t[m_act]--;
        if (m_t[m_act] == 0) begin m_st = 3; m_los = m_act; m_flg = 1; end
      end
      if (m_st == 1 && prise) m_st = 2;
    end else if (m_st == 2) begin
      if (prise) m_st = 1;
    end
  endtask

  initial begin
    logic       r_tk, r_p, r_c;
    logic [2:0] r_b;

    //              tk  btn    p  c   st act los flg t0 t1 t2
    tbl[0]  = mk(0, 3'b001, 0, 0, 0, 0, 0, 0, 5, 5, 5); // held through reset: no start
    tbl[1]  = mk(0, 3'b000, 0, 0, 0, 0, 0, 0, 5, 5, 5);
    tbl[2]  = mk(0, 3'b001, 0, 0, 1, 1, 0, 0, 5, 5, 5); // start, player 1 runs
    tbl[3]  = mk(1, 3'b000, 0, 0, 1, 1, 0, 0, 5, 4, 5);
    tbl[4]  = mk(1, 3'b000, 0, 0, 1, 1, 0, 0, 5, 3, 5);
    tbl[5]  = mk(1, 3'b000, 0, 0, 1, 1, 0, 0, 5, 2, 5);
    tbl[6]  = mk(0, 3'b100, 0, 0, 1, 1, 0, 0, 5, 2, 5); // non-active button ignored
    tbl[7]  = mk(0, 3'b000, 1, 0, 2, 1, 0, 0, 5, 2, 5); // pause
    tbl[8]  = mk(1, 3'b000, 1, 0, 2, 1, 0, 0, 5, 2, 5);
    tbl[9]  = mk(1, 3'b010, 1, 0, 2, 1, 0, 0, 5, 2, 5);
    tbl[10] = mk(1, 3'b000, 1, 0, 2, 1, 0, 0, 5, 2, 5);
    tbl[11] = mk(1, 3'b000, 1, 0, 2, 1, 0, 0, 5, 2, 5);
    tbl[12] = mk(0, 3'b000, 0, 0, 2, 1, 0, 0, 5, 2, 5);
    tbl[13] = mk(0, 3'b000, 1, 0, 1, 1, 0, 0, 5, 2, 5); // resume
    tbl[14] = mk(0, 3'b000, 0, 0, 1, 1, 0, 0, 5, 2, 5);
    tbl[15] = mk(0, 3'b010, 1, 0, 2, 2, 0, 0, 5, 2, 5); // handover + pause together
    tbl[16] = mk(0, 3'b000, 0, 0, 2, 2, 0, 0, 5, 2, 5);
    tbl[17] = mk(0, 3'b000, 1, 0, 1, 2, 0, 0, 5, 2, 5);
    tbl[18] = mk(0, 3'b100, 0, 0, 1, 0, 0, 0, 5, 2, 5);
    tbl[19] = mk(0, 3'b000, 0, 0, 1, 0, 0, 0, 5, 2, 5);
    tbl[20] = mk(0, 3'b001, 0, 0, 1, 1, 0, 0, 5, 2, 5);
    tbl[21] = mk(1, 3'b000, 0, 0, 1, 1, 0, 0, 5, 1, 5);
    tbl[22] = mk(1, 3'b000, 0, 0, 3, 1, 1, 1, 5, 0, 5); // flag falls
    tbl[23] = mk(1, 3'b010, 0, 0, 3, 1, 1, 1, 5, 0, 5);
    tbl[24] = mk(1, 3'b000, 1, 0, 3, 1, 1, 1, 5, 0, 5);
    tbl[25] = mk(0, 3'b000, 0, 1, 0, 0, 0, 0, 5, 5, 5); // clear from WIN
    tbl[26] = mk(1, 3'b010, 0, 0, 1, 2, 0, 0, 5, 5, 5);
    tbl[27] = mk(1, 3'b000, 0, 0, 1, 2, 0, 0, 5, 5, 4);
    tbl[28] = mk(0, 3'b000, 0, 1, 0, 0, 0, 0, 5, 5, 5);
    tbl[29] = mk(0, 3'b110, 0, 0, 1, 2, 0, 0, 5, 5, 5); // lowest simultaneous press wins
    tbl[30] = mk(1, 3'b001, 1, 1, 0, 0, 0, 0, 5, 5, 5); // clear beats everything

    rst_a_n = 1'b0; rst_b_n = 1'b0;
    bus_a.tick = 1'b0; bus_a.buttons = 3'b001; bus_a.pause_btn = 1'b0; bus_a.clear = 1'b0;
    bus_b.tick = 1'b0; bus_b.buttons = 4'b0000; bus_b.pause_btn = 1'b0; bus_b.clear = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_a("reset_a", 0, 0, 0, 0, 5, 5, 5);
    check_b("reset_b", 0, 0, B_START, B_START, B_START, B_START);
    @(negedge clk);
    rst_a_n = 1'b1; rst_b_n = 1'b1;

    for (int i = 0; i < 31; i++) begin
      drive_a(tbl[i].tick, tbl[i].btn, tbl[i].pse, tbl[i].clr);
      check_a($sformatf("vec%0d", i), tbl[i].st, tbl[i].act, tbl[i].los, tbl[i].flg,
              tbl[i].t0, tbl[i].t1, tbl[i].t2);
    end

    // Random play on A against the model.
    drive_a(1'b0, 3'b000, 1'b0, 1'b1);
    m_st = 0; m_act = 0; m_los = 0; m_flg = 0; m_pb = 3'b000; m_pp = 1'b0;
    for (int k = 0; k < A_N; k++) m_t[k] = A_START;
    check_a("rand_init", m_st, m_act, m_los, m_flg, m_t[0], m_t[1], m_t[2]);
    r_b = 3'b000; r_p = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      r_tk = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 3) == 0) r_b = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 15) == 0) r_p = ~r_p;
      r_c = ($urandom_range(0, 39) == 0);
      model_a(r_tk, r_b, r_p, r_c);
      drive_a(r_tk, r_b, r_p, r_c);
      check_a("rand", m_st, m_act, m_los, m_flg, m_t[0], m_t[1], m_t[2]);
    end

    // Increment saturation and handover/tick collision on B.
    drive_b(1'b0, 4'b0001);
    check_b("b_start", 1, 1, 1020, 1020, 1020, 1020);
    for (int p = 1; p < 4; p++) begin
      drive_b(1'b0, 4'b0000);
      drive_b(1'b0, 4'(1 << p));
    end
    check_b("b_inc", 1, 0, 1020, 1022, 1022, 1022);
    drive_b(1'b0, 4'b0000);
    drive_b(1'b0, 4'b0001);
    drive_b(1'b0, 4'b0000);
    drive_b(1'b0, 4'b0010);
    check_b("b_sat", 1, 2, 1022, 1023, 1022, 1022);
    drive_b(1'b1, 4'b0000);
    check_b("b_tick", 1, 2, 1022, 1023, 1021, 1022);
    drive_b(1'b1, 4'b0100);
    check_b("b_ho_tick", 1, 3, 1022, 1023, 1023, 1022);

    // Asynchronous reset mid-game.
    #2 rst_b_n = 1'b0;
    #1;
    check_b("b_mid_reset", 0, 0, B_START, B_START, B_START, B_START);
    @(negedge clk);
    rst_b_n = 1'b1;
    @(posedge clk); #1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/multi_player_clock_fsm.md
Name: multi_player_clock_fsm

Overview:
- Parametrised N-player game clock controller; the next generation of the two-player chess timer FSM.
- Owns the per-player countdown registers internally, so no external counters are needed.
- Adds per-move time increment, pause/resume and synchronous new-game clear.
- Sits between debounced push-buttons plus a 1 Hz tick enable and the seven-segment display/LED drivers.

Parameters:
- N_PLAYERS, 2, number of players; legal range 2..8.
- CNT_W, 10, width of each player's time counter in seconds.
- START_TIME, 600, value loaded into every counter in IDLE; must be < 2^CNT_W.
- INCREMENT, 0, seconds added to the outgoing player's counter on each handover; saturates at 2^CNT_W-1.
- WARN_TIME, 30, low-time threshold; used only with CLOCK_WARN_EN.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- tick  in  1  one-cycle pulse, 1 Hz; decrements the active counter.
- buttons  in  N_PLAYERS  level inputs, already debounced; bit k = player k "end my move".
- pause_btn  in  1  level input; each rising edge toggles pause.
- clear  in  1  synchronous return to IDLE from any state.
- times  out  N_PLAYERS*CNT_W  counter k at bits [k*CNT_W +: CNT_W].
- active_idx  out  IW  index of the running player; IW = max(1, clog2(N_PLAYERS)).
- loser_idx  out  IW  index of the player whose flag fell; valid in WIN.
- flag  out  1  high in WIN.
- o_state  out  2  IDLE=00, RUN=01, PAUSE=10, WIN=11.
- low_time  out  1  low-time warning; see Optional Feature.

Behaviour:
- Async reset: state IDLE; all times = START_TIME; active_idx = 0; loser_idx = 0; flag = 0; low_time = 0; edge-detect registers = 0.
- Edge detection: buttons and pause_btn are registered; only a rising edge (prev 0, now 1) counts. A level held high through reset release produces no event.
- All outputs are registered. Every transition is visible one cycle after the causing edge.
- IDLE:
  - Every counter is held at START_TIME.
  - A rising edge on button k makes active_idx = (k+1) mod N_PLAYERS and moves to RUN.
  - Simultaneous edges in IDLE: the lowest k wins.
  - pause_btn is ignored.
- RUN:
  - tick decrements times[active_idx].
  - An edge on the active player's button performs a handover:
    - times[active] += INCREMENT, saturating at 2^CNT_W-1;
    - active_idx = (active+1) mod N_PLAYERS.
  - Edges on non-active buttons are ignored.
  - Handover and tick in the same cycle: the handover wins and no decrement is applied.
  - When a decrement makes the counter 0: next state WIN, loser_idx = active, flag = 1.
  - A counter never wraps below 0.
- PAUSE:
  - Entered from RUN on a pause_btn edge; a second edge returns to RUN with the same active_idx.
  - Ticks and buttons are ignored; counters are frozen.
  - If a pause edge and a handover occur in the same RUN cycle, the handover applies first, then the state enters PAUSE.
- WIN:
  - Terminal state; counters are frozen and the 0 is displayed.
  - Only clear or reset leaves it.
- clear: from any state, the next cycle is IDLE with counters reloaded, active_idx = 0 and flag = 0. clear takes priority over all other inputs.
- Reset mid-game: immediate return to the reset values listed above.
- The counter update and the WIN detection use the same registered next-value, so there is no one-cycle lag at the flag.

Optional Feature:
- Macro: CLOCK_WARN_EN.
- Defined: low_time is registered high when state is RUN or PAUSE and times[active_idx] <= WARN_TIME and the counter is nonzero. It is low in IDLE and WIN, and updates in the same cycle as the counter.
- Undefined: low_time is tied to 0, no comparator logic is built, and WARN_TIME is unused.

Test Plan:
- Reset with N_PLAYERS=3, START_TIME=5: times all 5, o_state=00, active_idx=0, flag=0. Hold buttons[0] high across reset release: state stays IDLE.
- buttons[0] edge in IDLE -> RUN, active_idx=1; 3 ticks -> times[1]=2, times[0]=times[2]=5; buttons[2] edge -> ignored.
- INCREMENT=2, START_TIME=1020, CNT_W=10: handover from a player at 1022 -> counter saturates at 1023. Handover coincident with tick -> no decrement, increment applied.
- Active counter 1 and tick -> counter 0, o_state=11, flag=1, loser_idx=active. Further ticks and buttons -> no change; clear -> IDLE, times reloaded.
- pause_btn edge in RUN -> o_state=10; 4 ticks -> counters unchanged; second edge -> RUN, same active_idx. Pause edge plus handover in the same cycle -> active advances, then PAUSE.
- CLOCK_WARN_EN with WARN_TIME=3: low_time rises when the active counter goes 4->3, stays high in PAUSE, and drops to 0 on WIN or clear. Without the macro, low_time=0 throughout.
